pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, default 32: width of every address port and register.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded by reset.
REQ-003 Parameter TRAP_VECTOR, default 32'h0000_0100: PC value loaded on a trap or a misaligned redirect.
REQ-004 Parameter C_EXT, default 0: 1 enables 16-bit instruction steps and 2-byte alignment.
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port stall_i, input, 1: holds the PC.
REQ-008 Port redirect_i, input, 1: taken branch or jump.
REQ-009 Port target_i, input, XLEN: redirect target address.
REQ-010 Port trap_i, input, 1: exception request.
REQ-011 Port is_compressed_i, input, 1: current instruction is 16-bit; ignored when C_EXT=0.
REQ-012 Port halt_i, input, 1: halt request.
REQ-013 Port resume_i, input, 1: leave halt.
REQ-014 Port pc_o, output, XLEN: current PC.
REQ-015 Port pc_seq_o, output, XLEN: pc_o + step, combinational.
REQ-016 Port valid_o, output, 1: pc_o is a valid fetch address.
REQ-017 Port misalign_o, output, 1: one-cycle pulse on a misaligned redirect.
REQ-018 Port bad_addr_o, output, XLEN: last misaligned target captured.

Function
REQ-019 Step SHALL be 2 when C_EXT=1 and is_compressed_i=1; otherwise 4. The sum wraps modulo 2^XLEN, with no carry out.
REQ-020 Alignment SHALL require target_i[1:0]==0 when C_EXT=0, and target_i[0]==0 when C_EXT=1.
REQ-021 State machine SHALL have three states: BOOT, RUN, HALT.
- BOOT: entered on reset; valid_o=0; moves to RUN on the first clock edge after rst_n deasserts.
- RUN: valid_o=1.
- HALT: valid_o=0; PC held.
REQ-022 In RUN, the next PC SHALL follow this priority (first match wins):
- trap_i: PC := TRAP_VECTOR.
- redirect_i with aligned target: PC := target_i.
- redirect_i with misaligned target: PC := TRAP_VECTOR; misalign_o=1 on the following cycle; bad_addr_o := target_i.
- stall_i: PC held.
- otherwise: PC := pc_seq_o.
REQ-023 trap_i and redirect_i SHALL override stall_i.
REQ-024 halt_i in RUN SHALL take effect after that edge's PC update, then enter HALT.
REQ-025 In HALT, resume_i SHALL return to RUN with the PC unchanged. If halt_i and resume_i are both high, halt wins (stay in HALT).
REQ-026 In HALT, trap_i SHALL load TRAP_VECTOR and remain in HALT; redirect_i and stall_i are ignored.
REQ-027 bad_addr_o SHALL hold its value until the next misaligned redirect.
REQ-028 misalign_o SHALL be exactly one cycle wide per event.
REQ-029 pc_seq_o SHALL be valid in every state.

Reset
REQ-030 Asserting rst_n low at any time, including mid-redirect or in HALT, SHALL immediately force: PC=RESET_VECTOR, state=BOOT, valid_o=0, misalign_o=0, bad_addr_o=0.
REQ-031 Every register SHALL be on the asynchronous reset; none is left uninitialised.

Structure
REQ-032 A shared package SHALL hold the state enum (BOOT/RUN/HALT) and the default vector constants.
REQ-033 The incrementer SHALL be one sub-module, pc_incr (XLEN-wide, step 2/4), replacing the fixed +4 adder; all remaining logic stays in the top module.

Verification
REQ-034 Reset then release, no other stimulus:
- BOOT for 1 cycle with pc_o=0 and valid_o=0.
- Then pc_o = 0, 4, 8, ... with valid_o=1.
REQ-035 At pc_o=0x10, assert redirect_i with target 0x200 and stall_i=1 together -> next pc_o=0x200.
REQ-036 Redirect to 0x202:
- C_EXT=0: pc_o=0x100, misalign_o pulses 1 cycle, bad_addr_o=0x202.
- C_EXT=1: pc_o=0x202.
REQ-037 trap_i and redirect_i together -> pc_o=0x100. Separately, pc_o=0xFFFF_FFFC with no events -> next pc_o=0x0000_0000.
REQ-038 C_EXT=1 with is_compressed_i=1 from pc_o=0x40 -> 0x42, 0x44.
REQ-039 Halt and reset during halt:
- halt_i at pc_o=0x20 -> HALT, pc_o=0x24 held, valid_o=0.
- resume_i -> RUN, pc_o=0x28 on the next edge.
- rst_n pulsed low while in HALT -> pc_o=0 immediately.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: the sequencer state
// enum and the default reset/trap vectors.
package pc_sequencer_pkg;

    // Sequencer operating states.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Default vectors. The top module narrows them to XLEN.
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_sequencer_incr.sv
// Sequential-PC incrementer: adds 2 (compressed step) or 4 to the PC.
// The sum wraps modulo 2^XLEN and has no carry out.
module pc_incr #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            half_step_i,
    output logic [XLEN-1:0] sum_o
);

    logic [XLEN-1:0] step;

    // Choose the step size, then add it with natural modulo wrap.
    always_comb begin
        step  = half_step_i ? XLEN'(2) : XLEN'(4);
        sum_o = pc_i + step;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALT control, the redirect/trap
// priority, misaligned-redirect capture and the sequential-PC output.
//
// Handshake note: there is no valid/ready pair here. pc_o is a fetch address
// only while valid_o is high (RUN). Each control input is sampled on the
// rising edge and has no acknowledge. misalign_o is a registered pulse that
// is high for one cycle after each misaligned redirect.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
    parameter int              C_EXT        = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            trap_i,
    input  logic            is_compressed_i,
    input  logic            halt_i,
    input  logic            resume_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_seq_o,
    output logic            valid_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] bad_addr_o,
    output logic [1:0]      dbg_state_o
);

    localparam bit CEXT_ON = (C_EXT != 0);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] bad_addr_q, bad_addr_d;

    logic            half_step;
    logic            target_aligned;
    logic [XLEN-1:0] pc_seq;

    // Step size and target alignment both depend on the compressed-ISA option.
    always_comb begin
        half_step      = CEXT_ON && is_compressed_i;
        target_aligned = CEXT_ON ? ~target_i[0] : (target_i[1:0] == 2'b00);
    end

    pc_incr #(
        .XLEN(XLEN)
    ) u_incr (
        .pc_i       (pc_q),
        .half_step_i(half_step),
        .sum_o      (pc_seq)
    );

    // Next-state and next-PC selection. Trap beats redirect, and redirect
    // beats stall. A halt request takes effect after this edge's PC update.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = 1'b0;
        bad_addr_d = bad_addr_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (trap_i) begin
                    pc_d = TRAP_VECTOR;
                end else if (redirect_i && target_aligned) begin
                    pc_d = target_i;
                end else if (redirect_i) begin
                    pc_d       = TRAP_VECTOR;
                    misalign_d = 1'b1;
                    bad_addr_d = target_i;
                end else if (!stall_i) begin
                    pc_d = pc_seq;
                end
                if (halt_i) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (trap_i) begin
                    pc_d = TRAP_VECTOR;
                end
                if (resume_i && !halt_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
                pc_d    = RESET_VECTOR;
            end
        endcase
    end

    // State, PC and misalign bookkeeping registers. All are cleared by the
    // asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
            bad_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            bad_addr_q <= bad_addr_d;
        end
    end

    // Drive the outputs from the registers and the incrementer.
    always_comb begin
        pc_o        = pc_q;
        pc_seq_o    = pc_seq;
        valid_o     = (state_q == ST_RUN);
        misalign_o  = misalign_q;
        bad_addr_o  = bad_addr_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer. Two instances run side by side on the same
// stimulus: instance 0 has C_EXT=0 and instance 1 has C_EXT=1.
module tb_pc_sequencer;

    localparam logic [31:0] TRAP_V  = 32'h0000_0100;
    localparam logic [31:0] RESET_V = 32'h0000_0000;
    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        stall, redirect, trap, comp, halt, resume;
    logic [31:0] target;

    logic [31:0] pc0, pc1, seq0, seq1, bad0, bad1;
    logic        valid0, valid1, mis0, mis1;
    logic [1:0]  st0, st1;

    logic [31:0] pc_w[2], seq_w[2], bad_w[2];
    logic        valid_w[2], mis_w[2];
    assign pc_w[0] = pc0;    assign pc_w[1] = pc1;
    assign seq_w[0] = seq0;  assign seq_w[1] = seq1;
    assign bad_w[0] = bad0;  assign bad_w[1] = bad1;
    assign valid_w[0] = valid0; assign valid_w[1] = valid1;
    assign mis_w[0] = mis0;  assign mis_w[1] = mis1;

    pc_sequencer #(.C_EXT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_i(redirect),
        .target_i(target), .trap_i(trap), .is_compressed_i(comp),
        .halt_i(halt), .resume_i(resume), .pc_o(pc0), .pc_seq_o(seq0),
        .valid_o(valid0), .misalign_o(mis0), .bad_addr_o(bad0),
        .dbg_state_o(st0)
    );

    pc_sequencer #(.C_EXT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall), .redirect_i(redirect),
        .target_i(target), .trap_i(trap), .is_compressed_i(comp),
        .halt_i(halt), .resume_i(resume), .pc_o(pc1), .pc_seq_o(seq1),
        .valid_o(valid1), .misalign_o(mis1), .bad_addr_o(bad1),
        .dbg_state_o(st1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_pc[2], m_bad[2];
    logic        m_mis[2];
    int          m_mode[2];

    function automatic logic [31:0] m_step(int k);
        return (k == 1 && comp) ? 32'd2 : 32'd4;
    endfunction

    function automatic bit m_aligned(int k, logic [31:0] t);
        if (k == 1) return (t % 2) == 0;
        return (t % 4) == 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = RESET_V; m_bad[k] = 32'h0; m_mis[k] = 1'b0; m_mode[k] = M_BOOT;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] npc;
            int          nmode;
            npc = m_pc[k];
            nmode = m_mode[k];
            m_mis[k] = 1'b0;
            if (m_mode[k] == M_BOOT) begin
                nmode = M_RUN;
            end else if (m_mode[k] == M_RUN) begin
                if (trap) npc = TRAP_V;
                else if (redirect && m_aligned(k, target)) npc = target;
                else if (redirect) begin
                    npc = TRAP_V; m_mis[k] = 1'b1; m_bad[k] = target;
                end else if (!stall) npc = m_pc[k] + m_step(k);
                if (halt) nmode = M_HALT;
            end else begin
                if (trap) npc = TRAP_V;
                if (resume && !halt) nmode = M_RUN;
            end
            m_pc[k] = npc;
            m_mode[k] = nmode;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        stall = 0; redirect = 0; trap = 0; comp = 0; halt = 0; resume = 0;
        target = 32'h0;
    endtask

    // One rising edge. The model follows the edge, and outputs are sampled 1ns later.
    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] exp_pc;
        rst_n = 0;
        clear_inputs();
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pc_w[k] !== RESET_V || valid_w[k] !== 1'b0 || mis_w[k] !== 1'b0 || bad_w[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got pc=%h v=%b m=%b bad=%h expected pc=%h v=0 m=0 bad=0",
                         k, pc_w[k], valid_w[k], mis_w[k], bad_w[k], RESET_V);
            end
        end
        cycle();
        rst_n = 1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pc_w[k] !== 32'h0 || valid_w[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL boot_cycle[%0d]: got pc=%h v=%b expected pc=0 v=0", k, pc_w[k], valid_w[k]);
            end
        end
        exp_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (pc_w[k] !== exp_pc || valid_w[k] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL run_seq[%0d] step %0d: got pc=%h v=%b expected pc=%h v=1",
                             k, i, pc_w[k], valid_w[k], exp_pc);
                end
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_redirect_over_stall();
        cycle(); cycle();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pc_w[k] !== 32'h10) begin
                n_fail++;
                $display("FAIL reach_0x10[%0d]: got %h expected %h", k, pc_w[k], 32'h10);
            end
        end
        redirect = 1; stall = 1; target = 32'h200;
        cycle();
        clear_inputs();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pc_w[k] !== 32'h200) begin
                n_fail++;
                $display("FAIL redirect_stall[%0d]: got %h expected %h", k, pc_w[k], 32'h200);
            end
        end
        stall = 1;
        cycle();
        clear_inputs();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pc_w[k] !== 32'h200) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got %h expected %h", k, pc_w[k], 32'h200);
            end
        end
    endtask

    task automatic test_misalign();
        logic [31:0] e_pc[2], e_bad[2];
        logic        e_mis[2];
        redirect = 1; target = 32'h202;
        cycle();
        clear_inputs();
        e_pc[0] = 32'h100; e_mis[0] = 1; e_bad[0] = 32'h202;
        e_pc[1] = 32'h202; e_mis[1] = 0; e_bad[1] = 32'h0;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pc_w[k] !== e_pc[k] || mis_w[k] !== e_mis[k] || bad_w[k] !== e_bad[k]) begin
                n_fail++;
                $display("FAIL misalign_event[%0d]: got pc=%h m=%b bad=%h expected pc=%h m=%b bad=%h",
                         k, pc_w[k], mis_w[k], bad_w[k], e_pc[k], e_mis[k], e_bad[k]);
            end
        end
        cycle();
        e_pc[0] = 32'h104; e_pc[1] = 32'h206;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pc_w[k] !== e_pc[k] || mis_w[k] !== 1'b0 || bad_w[k] !== e_bad[k]) begin
                n_fail++;
                $display("FAIL misalign_after[%0d]: got pc=%h m=%b bad=%h expected pc=%h m=0 bad=%h",
                         k, pc_w[k], mis_w[k], bad_w[k], e_pc[k], e_bad[k]);
            end
        end
    endtask

    task automatic test_trap_and_wrap();
        trap = 1; redirect = 1; target = 32'h300;
        cycle();
        clear_inputs();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pc_w[k] !== TRAP_V) begin
                n_fail++;
                $display("FAIL trap_over_redirect[%0d]: got %h expected %h", k, pc_w[k], TRAP_V);
            end
        end
        redirect = 1; target = 32'hFFFF_FFFC;
        cycle();
        clear_inputs();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pc_w[k] !== 32'hFFFF_FFFC || seq_w[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL wrap_seq[%0d]: got pc=%h seq=%h expected pc=fffffffc seq=0", k, pc_w[k], seq_w[k]);
            end
        end
        cycle();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pc_w[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL wrap_pc[%0d]: got %h expected %h", k, pc_w[k], 32'h0);
            end
        end
    endtask

    task automatic test_compressed();
        logic [31:0] e_seq[2];
        redirect = 1; target = 32'h40;
        cycle();
        clear_inputs();
        comp = 1;
        #1;
        e_seq[0] = 32'h44; e_seq[1] = 32'h42;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (seq_w[k] !== e_seq[k]) begin
                n_fail++;
                $display("FAIL comp_seq[%0d]: got %h expected %h", k, seq_w[k], e_seq[k]);
            end
        end
        for (int i = 1; i <= 2; i++) begin
            cycle();
            e_seq[0] = 32'h40 + 32'(4 * i);
            e_seq[1] = 32'h40 + 32'(2 * i);
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (pc_w[k] !== e_seq[k]) begin
                    n_fail++;
                    $display("FAIL comp_pc[%0d] step %0d: got %h expected %h", k, i, pc_w[k], e_seq[k]);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_halt();
        logic [31:0] e_pc[7];
        logic        e_v[7];
        redirect = 1; target = 32'h20;
        cycle();
        clear_inputs();
        e_pc = '{32'h24, 32'h24, 32'h24, 32'h28, 32'h2C, 32'h2C, TRAP_V};
        e_v  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            clear_inputs();
            case (i)
                0: halt = 1;
                2: resume = 1;
                4: halt = 1;
                5: begin halt = 1; resume = 1; end
                6: begin trap = 1; redirect = 1; stall = 1; target = 32'h80; end
                default: ;
            endcase
            cycle();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (pc_w[k] !== e_pc[i] || valid_w[k] !== e_v[i]) begin
                    n_fail++;
                    $display("FAIL halt_seq[%0d] step %0d: got pc=%h v=%b expected pc=%h v=%b",
                             k, i, pc_w[k], valid_w[k], e_pc[i], e_v[i]);
                end
            end
        end
        clear_inputs();
        #2;
        rst_n = 0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pc_w[k] !== RESET_V || valid_w[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_reset[%0d]: got pc=%h v=%b expected pc=%h v=0", k, pc_w[k], valid_w[k], RESET_V);
            end
        end
        cycle();
        rst_n = 1;
        cycle();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (pc_w[k] !== RESET_V || valid_w[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL post_reset_run[%0d]: got pc=%h v=%b expected pc=%h v=1", k, pc_w[k], valid_w[k], RESET_V);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall    = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 5) == 0);
            trap     = ($urandom_range(0, 15) == 0);
            halt     = ($urandom_range(0, 19) == 0);
            resume   = ($urandom_range(0, 2) == 0);
            comp     = $urandom_range(0, 1);
            target   = $urandom;
            if ($urandom_range(0, 1) == 1) target = target & 32'hFFFF_FFFC;
            #1;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (seq_w[k] !== m_pc[k] + m_step(k)) begin
                    n_fail++;
                    $display("FAIL rand_seq[%0d] iter %0d: got %h expected %h", k, i, seq_w[k], m_pc[k] + m_step(k));
                end
            end
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 0;
                model_reset();
                #1;
                for (int k = 0; k < 2; k++) begin
                    n_checks++;
                    if (pc_w[k] !== RESET_V || valid_w[k] !== 1'b0 || mis_w[k] !== 1'b0 || bad_w[k] !== 32'h0) begin
                        n_fail++;
                        $display("FAIL rand_reset[%0d] iter %0d: got pc=%h v=%b m=%b bad=%h expected all reset",
                                 k, i, pc_w[k], valid_w[k], mis_w[k], bad_w[k]);
                    end
                end
            end
            cycle();
            rst_n = 1;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (pc_w[k] !== m_pc[k] || valid_w[k] !== (m_mode[k] == M_RUN) ||
                    mis_w[k] !== m_mis[k] || bad_w[k] !== m_bad[k]) begin
                    n_fail++;
                    $display("FAIL rand_state[%0d] iter %0d: got pc=%h v=%b m=%b bad=%h expected pc=%h v=%b m=%b bad=%h",
                             k, i, pc_w[k], valid_w[k], mis_w[k], bad_w[k],
                             m_pc[k], (m_mode[k] == M_RUN), m_mis[k], m_bad[k]);
                end
            end
        end
        clear_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_redirect_over_stall();
        test_misalign();
        test_trap_and_wrap();
        test_compressed();
        test_halt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
